// File: rtl/tpu_os_systolic_array.sv
// Output-stationary systolic MAC array with internal operand skew,
// saturating signed/unsigned accumulation and row-by-row result drain.
module tpu_os_systolic_array #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int K_WIDTH    = 16,
  localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [K_WIDTH-1:0]         cfg_k,
  input  logic                       cfg_signed,
  input  logic                       cfg_accumulate,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] in_a,
  input  logic [COLS*DATA_WIDTH-1:0] in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [COLS*ACC_WIDTH-1:0]  out_data,
  output logic [RW-1:0]              out_row,
  output logic                       out_last,
  output logic                       sat_flag,
  input  logic                       sat_clear,
  output logic [31:0]                beat_count
);

  localparam int NP = ROWS + COLS - 1;
  localparam int PW = 2*DATA_WIDTH + 1;
  localparam int FW = $clog2(NP + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, FLUSH, DRAIN, DONE
  } state_t;

  state_t               state;
  logic [K_WIDTH-1:0]   k_q;
  logic [K_WIDTH-1:0]   k_cnt;
  logic                 sgn_q;
  logic [FW-1:0]        fl_cnt;
  logic [RW-1:0]        row_q;
  logic                 accept;

  // Position p of a row/column line is the token seen by the PE on
  // diagonal p, so PE(i,j) reads index i+j of both its lines.
  logic [DATA_WIDTH-1:0] a_d [ROWS][NP];
  logic                  a_v [ROWS][NP];
  logic [DATA_WIDTH-1:0] b_d [COLS][NP];
  logic                  b_v [COLS][NP];

  logic signed [ACC_WIDTH-1:0] acc     [ROWS][COLS];
  logic signed [ACC_WIDTH-1:0] acc_nxt [ROWS][COLS];
  logic                        sat_any;
  logic signed [DATA_WIDTH:0]  ea, eb;
  logic signed [PW:0]          prod;
  logic signed [ACC_WIDTH:0]   sum;

  assign accept    = in_valid && in_ready;
  assign busy      = (state != IDLE);
  assign in_ready  = (state == LOAD);
  assign out_valid = (state == DRAIN);
  assign done      = (state == DONE);
  assign out_row   = row_q;
  assign out_last  = out_valid && (row_q == RW'(ROWS-1));

  always_comb begin
    out_data = '0;
    for (int j = 0; j < COLS; j++)
      out_data[j*ACC_WIDTH +: ACC_WIDTH] = acc[row_q][j];
  end

  always_comb begin
    sat_any = 1'b0;
    ea      = '0;
    eb      = '0;
    prod    = '0;
    sum     = '0;
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        acc_nxt[i][j] = acc[i][j];
        if (a_v[i][i+j] && b_v[j][i+j]) begin
          ea   = {sgn_q & a_d[i][i+j][DATA_WIDTH-1], a_d[i][i+j]};
          eb   = {sgn_q & b_d[j][i+j][DATA_WIDTH-1], b_d[j][i+j]};
          prod = (PW+1)'(ea) * (PW+1)'(eb);
          sum  = (ACC_WIDTH+1)'(acc[i][j]) + (ACC_WIDTH+1)'(prod);
          if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
            sat_any = 1'b1;
            acc_nxt[i][j] = sum[ACC_WIDTH]
              ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
              : {1'b0, {(ACC_WIDTH-1){1'b1}}};
          end else begin
            acc_nxt[i][j] = sum[ACC_WIDTH-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      k_q        <= '0;
      k_cnt      <= '0;
      sgn_q      <= 1'b0;
      fl_cnt     <= '0;
      row_q      <= '0;
      sat_flag   <= 1'b0;
      beat_count <= '0;
      for (int i = 0; i < ROWS; i++)
        for (int p = 0; p < NP; p++) begin
          a_d[i][p] <= '0;
          a_v[i][p] <= 1'b0;
        end
      for (int j = 0; j < COLS; j++)
        for (int p = 0; p < NP; p++) begin
          b_d[j][p] <= '0;
          b_v[j][p] <= 1'b0;
        end
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          acc[i][j] <= '0;
    end else begin
      if (accept)
        beat_count <= beat_count + 32'd1;
      if (sat_any)
        sat_flag <= 1'b1;
      else if (sat_clear)
        sat_flag <= 1'b0;

      for (int i = 0; i < ROWS; i++) begin
        a_d[i][0] <= in_a[i*DATA_WIDTH +: DATA_WIDTH];
        a_v[i][0] <= accept;
        for (int p = 1; p < NP; p++) begin
          a_d[i][p] <= a_d[i][p-1];
          a_v[i][p] <= a_v[i][p-1];
        end
      end
      for (int j = 0; j < COLS; j++) begin
        b_d[j][0] <= in_b[j*DATA_WIDTH +: DATA_WIDTH];
        b_v[j][0] <= accept;
        for (int p = 1; p < NP; p++) begin
          b_d[j][p] <= b_d[j][p-1];
          b_v[j][p] <= b_v[j][p-1];
        end
      end

      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          if (state == IDLE && start && !cfg_accumulate)
            acc[i][j] <= '0;
          else
            acc[i][j] <= acc_nxt[i][j];

      unique case (state)
        IDLE: if (start) begin
          k_q   <= cfg_k;
          sgn_q <= cfg_signed;
          k_cnt <= '0;
          row_q <= '0;
          state <= (cfg_k == '0) ? DRAIN : LOAD;
        end
        LOAD: if (accept) begin
          k_cnt <= k_cnt + K_WIDTH'(1);
          if (k_cnt + K_WIDTH'(1) == k_q) begin
            fl_cnt <= '0;
            state  <= FLUSH;
          end
        end
        FLUSH: begin
          fl_cnt <= fl_cnt + FW'(1);
          if (fl_cnt == FW'(NP-1)) begin
            row_q <= '0;
            state <= DRAIN;
          end
        end
        DRAIN: if (out_ready) begin
          if (row_q == RW'(ROWS-1))
            state <= DONE;
          else
            row_q <= row_q + RW'(1);
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_os_systolic_array.sv
// Scoreboard bench: 32-bit and 17-bit accumulator instances share stimulus;
// expected rows come from a plain-arithmetic matrix model.
module tb_tpu_os_systolic_array;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int DW = 8;
  localparam int KW = 16;
  localparam int W1 = 32;
  localparam int W2 = 17;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [KW-1:0]   cfg_k;
  logic            cfg_signed, cfg_accumulate, start;
  logic            in_valid, out_ready, sat_clear;
  logic [R*DW-1:0] in_a;
  logic [C*DW-1:0] in_b;

  logic            busy, done, in_ready, out_valid, out_last, sat_flag;
  logic [1:0]      out_row;
  logic [C*W1-1:0] out_data;
  logic [31:0]     beat_count;

  logic            s_busy, s_done, s_in_ready, s_out_valid, s_out_last;
  logic            s_sat_flag;
  logic [1:0]      s_out_row;
  logic [C*W2-1:0] s_out_data;
  logic [31:0]     s_beat_count;

  tpu_os_systolic_array #(.ROWS(R), .COLS(C), .DATA_WIDTH(DW),
    .ACC_WIDTH(W1), .K_WIDTH(KW)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_k(cfg_k), .cfg_signed(cfg_signed),
    .cfg_accumulate(cfg_accumulate), .start(start), .busy(busy),
    .done(done), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
    .out_last(out_last), .sat_flag(sat_flag), .sat_clear(sat_clear),
    .beat_count(beat_count));

  tpu_os_systolic_array #(.ROWS(R), .COLS(C), .DATA_WIDTH(DW),
    .ACC_WIDTH(W2), .K_WIDTH(KW)) u_sat (
    .clk(clk), .rst_n(rst_n), .cfg_k(cfg_k), .cfg_signed(cfg_signed),
    .cfg_accumulate(cfg_accumulate), .start(start), .busy(s_busy),
    .done(s_done), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_data(s_out_data), .out_row(s_out_row),
    .out_last(s_out_last), .sat_flag(s_sat_flag), .sat_clear(sat_clear),
    .beat_count(s_beat_count));

  typedef struct {
    logic [1:0]      row;
    logic [C*W1-1:0] d1;
    logic [C*W2-1:0] d2;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  longint      m1 [R][C];
  longint      m2 [R][C];
  bit          msat1, msat2;
  int unsigned mbeats;
  int          ba [64][R];
  int          bb [64][C];
  int          rdy_mode = 0;
  int          stall_n = 0;

  task automatic check(string name, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic longint ext(int v, bit sgn);
    return (sgn && v > 127) ? longint'(v - 256) : longint'(v);
  endfunction

  function automatic longint sat_add(longint a, longint p, int w,
                                     output bit s);
    longint mx = (longint'(1) <<< (w-1)) - 1;
    longint mn = -(longint'(1) <<< (w-1));
    longint t  = a + p;
    s = 1'b0;
    if (t > mx) begin t = mx; s = 1'b1; end
    else if (t < mn) begin t = mn; s = 1'b1; end
    return t;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) begin
        m1[i][j] = 0;
        m2[i][j] = 0;
      end
  endtask

  // C += A*B with per-MAC saturation, then queue the ROWS result rows
  task automatic model_tile(int k, bit sgn, bit accum);
    exp_t   e;
    bit     s;
    longint p;
    if (!accum) model_clear();
    for (int kk = 0; kk < k; kk++)
      for (int i = 0; i < R; i++)
        for (int j = 0; j < C; j++) begin
          p = ext(ba[kk][i], sgn) * ext(bb[kk][j], sgn);
          m1[i][j] = sat_add(m1[i][j], p, W1, s);
          if (s) msat1 = 1'b1;
          m2[i][j] = sat_add(m2[i][j], p, W2, s);
          if (s) msat2 = 1'b1;
        end
    for (int i = 0; i < R; i++) begin
      e.row = 2'(i);
      for (int j = 0; j < C; j++) begin
        e.d1[j*W1 +: W1] = m1[i][j][W1-1:0];
        e.d2[j*W2 +: W2] = m2[i][j][W2-1:0];
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start(int k, bit sgn, bit accum);
    cfg_k = KW'(k);
    cfg_signed = sgn;
    cfg_accumulate = accum;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic feed_beat(int kk);
    bit ok;
    int tmo = 0;
    in_valid = 1'b1;
    for (int i = 0; i < R; i++) in_a[i*DW +: DW] = DW'(ba[kk][i]);
    for (int j = 0; j < C; j++) in_b[j*DW +: DW] = DW'(bb[kk][j]);
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      tmo++;
    end while (!ok && tmo < 50);
    if (!ok) check("in_ready_wait", 0, 1);
    else mbeats++;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int tmo = 0;
    do begin
      @(negedge clk);
      tmo++;
    end while (busy && tmo < 500);
    if (busy) check("idle_wait", 0, 1);
    check("rows_drained", 128'(exp_q.size()), 0);
    check("beat_count", beat_count, mbeats);
    check("sat_flag_32", sat_flag, msat1);
    check("sat_flag_17", s_sat_flag, msat2);
  endtask

  // gap: 0 back-to-back, 1 one bubble between beats, 2 random bubbles
  task automatic run_tile(int k, bit sgn, bit accum, int gap);
    model_tile(k, sgn, accum);
    pulse_start(k, sgn, accum);
    for (int kk = 0; kk < k; kk++) begin
      if ((gap == 1 && kk > 0) || (gap == 2 && $urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      feed_beat(kk);
    end
    wait_idle();
  endtask

  task automatic fill_const(int k, int a, int b);
    for (int kk = 0; kk < k; kk++) begin
      for (int i = 0; i < R; i++) ba[kk][i] = a;
      for (int j = 0; j < C; j++) bb[kk][j] = b;
    end
  endtask

  task automatic fill_rand(int k);
    for (int kk = 0; kk < k; kk++) begin
      for (int i = 0; i < R; i++) ba[kk][i] = int'($urandom_range(0, 255));
      for (int j = 0; j < C; j++) bb[kk][j] = int'($urandom_range(0, 255));
    end
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1: out_ready = ($urandom_range(0, 3) != 0);
        2: if (out_valid && out_row == 2'd1 && stall_n < 5) begin
             out_ready = 1'b0;
             stall_n++;
           end else begin
             out_ready = 1'b1;
           end
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted row
  bit              done_pend = 1'b0;
  bit              hold_v = 1'b0;
  logic [C*W1-1:0] hold_d;
  logic [1:0]      hold_r;
  exp_t            me;

  always @(negedge clk) begin
    if (rst_n) begin
      if (done_pend) begin
        check("done_pulse", done, 1);
        check("valid_after_last", out_valid, 0);
        done_pend = 1'b0;
      end
      if (hold_v && out_valid) begin
        check("stall_data", out_data, hold_d);
        check("stall_row", out_row, hold_r);
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      hold_r = out_row;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_row", 1, 0);
        end else begin
          me = exp_q.pop_front();
          check("out_row", out_row, me.row);
          check("out_last", out_last, me.row == 2'(R-1));
          check("out_data_32", out_data, me.d1);
          check("sat_valid_17", s_out_valid, 1);
          check("out_data_17", s_out_data, me.d2);
          if (out_last) done_pend = 1'b1;
        end
      end
    end else begin
      done_pend = 1'b0;
      hold_v = 1'b0;
    end
  end

  initial begin
    cfg_k = '0; cfg_signed = 1'b0; cfg_accumulate = 1'b0;
    start = 1'b0; in_valid = 1'b0; sat_clear = 1'b0;
    in_a = '0; in_b = '0;
    msat1 = 1'b0; msat2 = 1'b0; mbeats = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_beat_count", beat_count, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // identity A against B rows 1..16
    for (int kk = 0; kk < 4; kk++) begin
      for (int i = 0; i < R; i++) ba[kk][i] = (i == kk) ? 1 : 0;
      for (int j = 0; j < C; j++) bb[kk][j] = 4*kk + j + 1;
    end
    run_tile(4, 1'b0, 1'b0, 0);

    fill_const(2, 253, 5);
    run_tile(2, 1'b1, 1'b0, 0);
    run_tile(2, 1'b0, 1'b0, 0);

    fill_rand(3);
    run_tile(3, 1'b1, 1'b0, 0);
    rdy_mode = 2;
    stall_n = 0;
    run_tile(3, 1'b1, 1'b0, 1);
    check("stall_applied", stall_n, 5);
    rdy_mode = 0;

    fill_const(2, 1, 1);
    run_tile(2, 1'b0, 1'b0, 0);
    run_tile(2, 1'b0, 1'b1, 0);
    run_tile(0, 1'b0, 1'b0, 0);

    fill_const(4, 255, 255);
    run_tile(4, 1'b0, 1'b0, 0);
    for (int kk = 0; kk < 4; kk++)
      for (int i = 0; i < R; i++) ba[kk][i] = (i == kk) ? 1 : 0;
    run_tile(4, 1'b0, 1'b0, 0);
    sat_clear = 1'b1;
    @(posedge clk); #1;
    sat_clear = 1'b0;
    msat1 = 1'b0;
    msat2 = 1'b0;
    check("sat_cleared_17", s_sat_flag, 0);
    fill_const(4, 255, 255);
    run_tile(4, 1'b0, 1'b0, 0);

    // abort mid-LOAD after 2 of 4 beats
    pulse_start(4, 1'b0, 1'b0);
    feed_beat(0);
    feed_beat(1);
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", in_ready, 0);
    check("arst_busy", busy, 0);
    check("arst_sat_flag_17", s_sat_flag, 0);
    check("arst_beat_count", beat_count, 0);
    model_clear();
    msat1 = 1'b0;
    msat2 = 1'b0;
    mbeats = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    fill_const(1, 1, 1);
    run_tile(1, 1'b0, 1'b1, 0);

    rdy_mode = 1;
    for (int t = 0; t < 10; t++) begin
      int k = int'($urandom_range(0, 6));
      fill_rand(k);
      @(posedge clk); #1;
      run_tile(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tpu_os_systolic_array.md
Name: tpu_os_systolic_array

Overview:
- Parametrised output-stationary systolic matrix engine; computes C[ROWS x COLS] = sum over k of A[:,k] * B[k,:] for a programmable inner dimension K.
- Operands are streamed one k-beat per handshake. Input skew is generated internally, and results are drained row by row over a valid/ready port.
- Adds signed/unsigned INT modes, saturating accumulation, multi-tile accumulate and output back-pressure.
- Sits between the TPU operand buffers and the result writeback path.

Parameters:
- ROWS, 4, PE rows; also the A vector length (min 1).
- COLS, 4, PE columns; also the B vector length (min 1).
- DATA_WIDTH, 8, operand width.
- ACC_WIDTH, 32, accumulator/result width; must be >= 2*DATA_WIDTH+1.
- K_WIDTH, 16, width of cfg_k.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_k  in  K_WIDTH  inner dimension K; sampled on start
- cfg_signed  in  1  1 = operands two's complement, 0 = unsigned; sampled on start
- cfg_accumulate  in  1  1 = keep accumulators from previous tile, 0 = clear; sampled on start
- start  in  1  single-cycle pulse; honoured only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in DONE
- in_valid  in  1  A/B beat valid
- in_ready  out  1  high only in LOAD
- in_a  in  ROWS*DATA_WIDTH  A column k; element i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_b  in  COLS*DATA_WIDTH  B row k; element j at bits [j*DATA_WIDTH +: DATA_WIDTH]
- out_valid  out  1  result row valid
- out_ready  in  1  result row accepted
- out_data  out  COLS*ACC_WIDTH  C row out_row; element j at bits [j*ACC_WIDTH +: ACC_WIDTH]
- out_row  out  $clog2(ROWS) (min 1)  index of the row presented
- out_last  out  1  high with the final row (out_row == ROWS-1)
- sat_flag  out  1  sticky: any accumulator saturated
- sat_clear  in  1  clears sat_flag
- beat_count  out  32  accepted input beats since reset (free-running, wraps)

Behaviour:
- Reset values: all outputs 0; all accumulators 0; state IDLE.
- Reset mid-operation: return to IDLE immediately; clear all state including accumulators.

States:
- IDLE -> (start): if cfg_k == 0, go to DRAIN; otherwise go to LOAD.
- LOAD -> FLUSH after the K-th accepted beat (in_valid && in_ready).
- FLUSH lasts exactly ROWS+COLS-1 cycles, then -> DRAIN.
- DRAIN -> DONE when the row with out_last is accepted.
- DONE -> IDLE after 1 cycle.
- start outside IDLE is ignored; configuration is not re-sampled.
- If cfg_accumulate == 0 on start, all accumulators are cleared in the start cycle.

Data path:
- An accepted beat injects A[i] into row i delayed by i cycles and B[j] into column j delayed by j cycles.
- Each operand carries a valid bit. A cycle with no accepted beat injects a bubble (valid = 0).
- Operands advance one PE per cycle: A moves right, B moves down.
- PE(i,j) performs a MAC only when the arriving A and B tokens are both valid. Skew guarantees alignment, so the beat accepted at cycle t updates PE(i,j) at cycle t+i+j+1.
- Bubbles in LOAD are legal and must not corrupt results.

Arithmetic:
- Operands are sign-extended or zero-extended per cfg_signed; the product is 2*DATA_WIDTH+1 bits.
- Accumulator is signed ACC_WIDTH; each MAC adds the product with saturation to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
- Saturation sets sat_flag. If sat_clear and a new saturation occur in the same cycle, the set wins.

Drain:
- Rows are presented in order 0..ROWS-1.
- out_data, out_row and out_last stay stable while out_valid && !out_ready.
- out_valid deasserts in the cycle after the last row is accepted.
- Accumulators are left intact after DRAIN, ready for the next tile when cfg_accumulate = 1.
- beat_count increments on every accepted beat.

Test Plan:
- Default params, cfg_signed=0, K=4, A = identity column stream, B rows = {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16} -> 4 rows out equal to B; out_last on row 3; done 1 cycle later; beat_count = 4.
- cfg_signed=1, K=2, all A = -3, all B = 5 -> every C element = -30 (0xFFFFFFE2); repeat with cfg_signed=0 on the same bytes (253, 5) -> 2530.
- K=3 with in_valid toggling 1,0,1,0,1 and out_ready held low for 5 cycles on row 1 -> results identical to the gap-free run; out_data/out_row stable throughout the stall.
- Tile accumulate: two starts, K=2 each, A = B = 1, cfg_accumulate 0 then 1 -> C = 2 then 4; a third start with cfg_accumulate=0 and K=0 -> rows of 0.
- ACC_WIDTH=17, cfg_signed=0, K=4, A = B = 255 -> C = 65535 (saturated); sat_flag = 1 until sat_clear, then 0.
- rst_n asserted mid-LOAD after 2 of K=4 beats -> in_ready=0, busy=0, sat_flag=0; next start with cfg_accumulate=1 and K=1, A = B = 1 -> C = 1 (accumulators were cleared by reset).
